lr1_sweep_capture: RTL and testbench

//   On-chip self-test sequencer for the LR1 combinational logic under test.

---
 rtl/lr1_sweep_capture.sv | 92 +++++++++
 tb/tb_lr1_sweep_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lr1_sweep_capture.sv
// rtl/lr1_sweep_capture.sv - self-test sequencer sweeping {X,X,X} codes and capturing LED responses
// Holds each code for DWELL_CYCLES, stores one sample per code and XOR-accumulates a checksum.
module lr1_sweep_capture #(
  parameter int DWELL_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [11:0] sw_out,
  input  logic [11:0] led_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] checksum,
  input  logic        rd_en,
  input  logic [3:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        rd_valid
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      x;
  logic [3:0]      x_dec;
  logic [CW-1:0]   cnt;
  logic [11:0]     mem [16];

  assign x_dec = x - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      x        <= 4'hF;
      sw_out   <= 12'hFFF;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= 12'h000;
      cnt      <= '0;
      rd_data  <= 12'h000;
      rd_valid <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 12'h000;
      end
    end else begin
      // Non-blocking read of mem gives the pre-write value on a same-edge collision
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_DRIVE;
            x        <= 4'hF;
            sw_out   <= 12'hFFF;
            cnt      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            checksum <= 12'h000;
          end
        end
        S_DRIVE: begin
          if (cnt == CNT_LAST) begin
            mem[x]   <= led_in;
            checksum <= checksum ^ led_in;
            cnt      <= '0;
            if (x != 4'h0) begin
              x      <= x_dec;
              sw_out <= {x_dec, x_dec, x_dec};
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lr1_sweep_capture.sv
// tb/tb_lr1_sweep_capture.sv - scoreboard bench for lr1_sweep_capture
// Reference model: per-code response table, expected store and checksum updated at each dwell boundary.
module tb_lr1_sweep_capture;

  localparam int DW = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] sw_out;
  logic [11:0] led_in;
  logic        busy;
  logic        done;
  logic [11:0] checksum;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic        rd_valid;

  logic [11:0] resp [16];
  logic [11:0] model_mem [16];
  logic [11:0] model_ck;
  logic [11:0] exp_q [$];
  logic [11:0] last_rd;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  assign led_in = resp[sw_out[3:0]];

  lr1_sweep_capture #(.DWELL_CYCLES(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sw_out   (sw_out),
    .led_in   (led_in),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Read-port monitor: pops expected data whenever a read was accepted at the edge
  logic ev;
  logic [11:0] e;
  always @(posedge clk) begin
    ev = rd_en && !rst;
    #1;
    if (rst) begin
      last_rd = 12'h000;
    end else if (ev) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_valid_hi", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'(e));
        last_rd = e;
      end
    end else begin
      chk("rd_valid_lo", 32'(rd_valid), 32'd0);
      chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model_mem[i] = 12'h000;
    model_ck = 12'h000;
  endtask

  task automatic set_loopback();
    for (int i = 0; i < 16; i++) resp[i] = {i[3:0], i[3:0], i[3:0]};
  endtask

  // Called at posedge+1; leaves the bench at posedge+1
  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1;
      rd_addr = a[3:0];
      exp_q.push_back(model_mem[a]);
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_sweep(input int pulse_at, input int abort_at);
    int n;
    int code;
    int c;
    n = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_ck = 12'h000;
    chk("start_sw", 32'(sw_out), 32'hFFF);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_ck", 32'(checksum), 32'd0);
    while (n < 400) begin
      rd_en = ($urandom_range(0, 3) == 0);
      rd_addr = 4'($urandom_range(0, 15));
      if ((n % DW) == DW - 1 && n < 16 * DW && $urandom_range(0, 1) == 1) begin
        rd_en = 1'b1;
        rd_addr = 4'(15 - n / DW);
      end
      if (rd_en) exp_q.push_back(model_mem[rd_addr]);
      start = (n + 1 == pulse_at);
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if ((n % DW) == 0 && n <= 16 * DW) begin
        c = 16 - n / DW;
        model_mem[c] = resp[c];
        model_ck = model_ck ^ resp[c];
      end
      if (n < 16 * DW) begin
        code = 15 - n / DW;
        if ((n % DW) == 0 || (n % DW) == DW - 1)
          chk("sw_code", 32'(sw_out), 32'({code[3:0], code[3:0], code[3:0]}));
        chk("busy_mid", 32'(busy), 32'd1);
        chk("done_mid", 32'(done), 32'd0);
      end
      if (n == abort_at) begin
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_sw", 32'(sw_out), 32'hFFF);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ck", 32'(checksum), 32'd0);
        chk("abort_rdv", 32'(rd_valid), 32'd0);
        chk("abort_rdd", 32'(rd_data), 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (done) break;
    end
    chk("done_latency", 32'(n), 32'(16 * DW));
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sw", 32'(sw_out), 32'h000);
    chk("end_ck", 32'(checksum), 32'(model_ck));
    rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky", 32'(done), 32'd1);
    chk("sw_hold", 32'(sw_out), 32'h000);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rd_en = 1'b0;
    rd_addr = 4'h0;
    last_rd = 12'h000;
    set_loopback();
    clear_model();
    #1;
    chk("rst_sw", 32'(sw_out), 32'hFFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ck", 32'(checksum), 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    read_all();

    run_sweep(0, -1);
    read_all();

    for (int i = 0; i < 16; i++) resp[i] = 12'h000;
    resp[7] = 12'h001;
    run_sweep(0, -1);
    chk("single_hit_ck", 32'(checksum), 32'h001);
    read_all();

    set_loopback();
    run_sweep(50, -1);
    read_all();

    run_sweep(0, 125);
    run_sweep(0, -1);
    read_all();

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) resp[i] = 12'($urandom);
      run_sweep((t == 1) ? int'($urandom_range(2, 300)) : 0, -1);
      read_all();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
